display_capture: RTL and testbench

- Receiving end of the multiplexed 7-segment display interface.
- Samples the anode and segment lines driven by the scanning display driver, waits for each strobe to settle, and decodes the segment patterns back into four BCD digits with per-digit blank, decimal-point, invalid and stale flags.
- Used as a loop-back checker on the board and as a scoreboard front-end in system simulation of the countdown design.

---
 rtl/display_pkg.sv | 26 ++
 rtl/display_capture_seg7_decode.sv | 32 +++
 rtl/display_capture.sv | 171 +++++++++++++++++
 tb/tb_display_capture.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment display capture path.
// Segment patterns are high-true, ordered gfedcba.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Normalised (high-true) sample of the display pins.
  typedef struct packed {
    logic [3:0] an;
    logic       dp;
    logic [6:0] seg;
  } sample_t;

endpackage

// File: rtl/display_capture_seg7_decode.sv
// Combinational decode of a high-true gfedcba segment pattern into BCD.
// All-off reads as blank; any non-decimal pattern reads as invalid.
module seg7_decode
  import display_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       blank_o,
  output logic       invalid_o
);

  always_comb begin
    bcd_o     = '0;
    blank_o   = 1'b0;
    invalid_o = 1'b0;
    case (seg_i)
      SEG_0:     bcd_o = 4'd0;
      SEG_1:     bcd_o = 4'd1;
      SEG_2:     bcd_o = 4'd2;
      SEG_3:     bcd_o = 4'd3;
      SEG_4:     bcd_o = 4'd4;
      SEG_5:     bcd_o = 4'd5;
      SEG_6:     bcd_o = 4'd6;
      SEG_7:     bcd_o = 4'd7;
      SEG_8:     bcd_o = 4'd8;
      SEG_9:     bcd_o = 4'd9;
      SEG_BLANK: blank_o = 1'b1;
      default:   invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/display_capture.sv
// Captures a scanned 7-segment display: debounces each anode strobe,
// decodes it into per-digit BCD/flags, and tracks staleness and frames.
module display_capture
  import display_pkg::*;
#(
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic        dp,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [3:0]  dp_out,
  output logic [3:0]  invalid,
  output logic [3:0]  stale,
  output logic        frame_valid,
  output logic        multi_an_err
);

  localparam logic [6:0]  SEG_XOR    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic        DP_XOR     = SEG_ACTIVE_LOW;
  localparam logic [3:0]  AN_XOR     = AN_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [7:0]  ACCEPT_CNT = 8'(STABLE_CYCLES - 2);
  localparam logic [20:0] AGE_LAST   = 21'(TIMEOUT_CYCLES - 1);

  logic [6:0]  seg_q;
  logic        dp_q;
  logic [3:0]  an_q;
  sample_t     cur;
  sample_t     prev_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        stable;
  logic        accept;
  logic [2:0]  n_active;
  logic [3:0]  commit_vec;
  logic        mae_d, mae_q;
  logic        fv_d, fv_q;
  logic [3:0]  seen_q, seen_d, seen_all;
  logic [15:0] dig_q, dig_d;
  logic [3:0]  blank_q, blank_d;
  logic [3:0]  dpo_q, dpo_d;
  logic [3:0]  inv_q, inv_d;
  logic [3:0]  stale_q, stale_d;
  logic [20:0] age_q [NUM_DIGITS];
  logic [20:0] age_d [NUM_DIGITS];
  logic [3:0]  dec_bcd;
  logic        dec_blank;
  logic        dec_invalid;

  assign cur.an  = an_q ^ AN_XOR;
  assign cur.dp  = dp_q ^ DP_XOR;
  assign cur.seg = seg_q ^ SEG_XOR;

  // Counter equals ACCEPT_CNT only once per stable run (it then climbs
  // past it and saturates), so acceptance lands on the edge it hits S-1.
  assign stable = (cur == prev_q);
  assign accept = stable && (cnt_q == ACCEPT_CNT);

  always_comb begin
    cnt_d = '0;
    if (stable) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end
  end

  always_comb begin
    n_active = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      n_active = n_active + {2'b00, cur.an[i]};
    end
  end

  assign commit_vec = (accept && n_active == 3'd1) ? cur.an : '0;
  assign mae_d      = accept && (n_active > 3'd1);

  seg7_decode u_decode (
    .seg_i     (cur.seg),
    .bcd_o     (dec_bcd),
    .blank_o   (dec_blank),
    .invalid_o (dec_invalid)
  );

  always_comb begin
    dig_d   = dig_q;
    blank_d = blank_q;
    dpo_d   = dpo_q;
    inv_d   = inv_q;
    stale_d = stale_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      age_d[i] = age_q[i];
      if (commit_vec[i]) begin
        dig_d[4*i +: 4] = dec_bcd;
        blank_d[i]      = dec_blank;
        dpo_d[i]        = cur.dp;
        inv_d[i]        = dec_invalid;
        age_d[i]        = '0;
        stale_d[i]      = 1'b0;
      end else begin
        if (age_q[i] != '1) begin
          age_d[i] = age_q[i] + 21'd1;
        end
        if (age_q[i] == AGE_LAST) begin
          stale_d[i] = 1'b1;
        end
      end
    end
  end

  assign seen_all = seen_q | commit_vec;

  always_comb begin
    seen_d = seen_all;
    fv_d   = 1'b0;
    if (seen_all == 4'hF) begin
      seen_d = '0;
      fv_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q   <= SEG_XOR;
      dp_q    <= DP_XOR;
      an_q    <= AN_XOR;
      prev_q  <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      blank_q <= '1;
      dpo_q   <= '0;
      inv_q   <= '0;
      stale_q <= '0;
      seen_q  <= '0;
      fv_q    <= 1'b0;
      mae_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      seg_q   <= seg;
      dp_q    <= dp;
      an_q    <= an;
      prev_q  <= cur;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      blank_q <= blank_d;
      dpo_q   <= dpo_d;
      inv_q   <= inv_d;
      stale_q <= stale_d;
      seen_q  <= seen_d;
      fv_q    <= fv_d;
      mae_q   <= mae_d;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign digits       = dig_q;
  assign blank        = blank_q;
  assign dp_out       = dpo_q;
  assign invalid      = inv_q;
  assign stale        = stale_q;
  assign frame_valid  = fv_q;
  assign multi_an_err = mae_q;

endmodule

// File: tb/tb_display_capture.sv
// Self-checking bench for display_capture: directed scenarios plus random
// strobes, compared every cycle against a behavioural run-length model.
module tb_display_capture;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  h_seg = '0;
  logic        h_dp = 1'b0;
  logic [3:0]  h_an = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  blank, dp_out, invalid, stale;
  logic        frame_valid, multi_an_err;

  assign seg = ~h_seg;
  assign dp  = ~h_dp;
  assign an  = ~h_an;

  display_capture #(
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1),
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .seg          (seg),
    .dp           (dp),
    .an           (an),
    .digits       (digits),
    .blank        (blank),
    .dp_out       (dp_out),
    .invalid      (invalid),
    .stale        (stale),
    .frame_valid  (frame_valid),
    .multi_an_err (multi_an_err)
  );

  always #5 clk = ~clk;

  logic [6:0] tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int fv_cnt = 0;
  int mae_cnt = 0;

  // Reference model: a strobe is taken once the same pin word has been
  // sampled STABLE times in a row; its effect appears one edge later.
  int         m_dig [4];
  logic [3:0] m_blank = 4'hF, m_dp = '0, m_inv = '0, m_stale = '0, m_seen = '0;
  int         m_age [4];
  logic       m_fv = 1'b0, m_mae = 1'b0, m_pend = 1'b0;
  logic [11:0] m_last = '0, m_pword = '0;
  int         m_run = 1;

  always @(posedge clk) begin
    logic [3:0]  cm;
    logic [11:0] w;
    logic [6:0]  s;
    int          idx;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_dig[i] = 0;
        m_age[i] = 0;
      end
      m_blank = 4'hF; m_dp = '0; m_inv = '0; m_stale = '0; m_seen = '0;
      m_fv = 1'b0; m_mae = 1'b0; m_pend = 1'b0;
      m_last = '0; m_run = 1;
    end else begin
      m_fv = 1'b0;
      m_mae = 1'b0;
      cm = '0;
      if (m_pend) begin
        if ($countones(m_pword[11:8]) > 1) m_mae = 1'b1;
        else if ($countones(m_pword[11:8]) == 1) cm = m_pword[11:8];
      end
      for (int i = 0; i < 4; i++) begin
        if (cm[i]) begin
          s = m_pword[6:0];
          idx = -1;
          for (int k = 0; k < 10; k++) if (tab[k] == s) idx = k;
          m_blank[i] = (s == 7'h00);
          m_inv[i]   = (s != 7'h00) && (idx < 0);
          m_dig[i]   = (idx < 0) ? 0 : idx;
          m_dp[i]    = m_pword[7];
          m_age[i]   = 0;
          m_stale[i] = 1'b0;
          m_seen[i]  = 1'b1;
        end else begin
          m_age[i]++;
          if (m_age[i] >= TIMEOUT) m_stale[i] = 1'b1;
        end
      end
      if (cm != 0 && m_seen == 4'hF) begin
        m_fv = 1'b1;
        m_seen = '0;
      end
      w = {h_an, h_dp, h_seg};
      if (w == m_last) m_run++;
      else begin
        m_last = w;
        m_run = 1;
      end
      m_pend = (m_run == STABLE);
      m_pword = w;
    end
  end

  function automatic logic [37:0] exp_vec();
    logic [15:0] d;
    for (int i = 0; i < 4; i++) d[4*i +: 4] = 4'(m_dig[i]);
    return {d, m_blank, m_dp, m_inv, m_stale, m_fv, m_mae};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [37:0] obs;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (frame_valid === 1'b1) fv_cnt++;
    if (multi_an_err === 1'b1) mae_cnt++;
    obs = {digits, blank, dp_out, invalid, stale, frame_valid, multi_an_err};
    n_cmp++;
    assert (obs === exp_vec()) else begin
      n_fail++;
      $error("FAIL model cyc=%0d observed=%h expected=%h", cyc, obs, exp_vec());
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    h_an = a; h_seg = s; h_dp = d;
    repeat (n) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digits"}, 32'(digits), 32'h0);
    check({tag, "_blank"}, 32'(blank), 32'hF);
    check({tag, "_flags"}, 32'({dp_out, invalid, stale, frame_valid, multi_an_err}), 32'h0);
  endtask

  initial begin
    int t0;
    int first;
    int d;
    logic [3:0] a;

    // reset
    tick(); tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // scan "1","2","0","5" on digits 3..0
    fv_cnt = 0;
    hold(4'b1000, 7'h06, 1'b0, 10);
    hold(4'b0100, 7'h5B, 1'b0, 10);
    hold(4'b0010, 7'h3F, 1'b0, 10);
    hold(4'b0001, 7'h6D, 1'b0, 10);
    hold(4'b0000, 7'h00, 1'b0, 3);
    check("scan_digits", 32'(digits), 32'h1205);
    check("scan_blank", 32'(blank), 32'h0);
    check("scan_invalid", 32'(invalid), 32'h0);
    check("scan_frames", 32'(fv_cnt), 32'd1);

    // glitching strobe on digit 0, then a stable "7"
    for (int i = 0; i < 5; i++) begin
      hold(4'b0001, 7'h4F, 1'b0, 2);
      hold(4'b0001, 7'h66, 1'b0, 2);
    end
    check("glitch_hold", 32'(digits[3:0]), 32'h5);
    hold(4'b0001, 7'h07, 1'b0, 10);
    check("glitch_commit", 32'(digits[3:0]), 32'h7);
    hold(4'b0000, 7'h00, 1'b0, 3);

    // two anodes at once, then complete the frame (digit 0 already seen)
    mae_cnt = 0;
    fv_cnt = 0;
    hold(4'b0011, 7'h3F, 1'b0, 10);
    check("multi_pulse", 32'(mae_cnt), 32'd1);
    check("multi_digits", 32'(digits), 32'h1207);
    check("multi_blank", 32'(blank), 32'h0);
    hold(4'b0010, 7'h66, 1'b0, 6);
    hold(4'b0100, 7'h7D, 1'b0, 6);
    check("seen_kept_pre", 32'(fv_cnt), 32'd0);
    hold(4'b1000, 7'h6F, 1'b1, 6);
    check("seen_kept_frame", 32'(fv_cnt), 32'd1);
    check("seen_digits", 32'(digits), 32'h9647);
    check("seen_dp", 32'(dp_out), 32'h8);

    // blank and invalid patterns
    fv_cnt = 0;
    hold(4'b0100, 7'h00, 1'b0, 8);
    hold(4'b0010, 7'h49, 1'b0, 8);
    check("blank2", 32'(blank[2]), 32'd1);
    check("blank2_digit", 32'(digits[11:8]), 32'd0);
    check("invalid1", 32'(invalid[1]), 32'd1);
    check("invalid1_blank", 32'(blank[1]), 32'd0);
    check("invalid1_digit", 32'(digits[7:4]), 32'd0);
    check("partial_frame", 32'(fv_cnt), 32'd0);
    hold(4'b1000, 7'h06, 1'b0, 8);
    hold(4'b0001, 7'h06, 1'b0, 8);
    check("full_frame", 32'(fv_cnt), 32'd1);

    // staleness of digit 3 while 0..2 keep scanning
    t0 = cyc;
    first = -1;
    hold(4'b1000, 7'h7F, 1'b1, 8);
    for (int r = 0; r < 6 && first < 0; r++) begin
      for (int k = 0; k < 18; k++) begin
        d = k / 6;
        hold(4'(1 << d), tab[d], 1'b0, 1);
        if (first < 0 && stale[3] === 1'b1) first = cyc;
      end
    end
    check("stale_time", 32'(first), 32'(t0 + 5 + TIMEOUT));
    check("stale_only3", 32'(stale), 32'h8);
    check("stale_hold", 32'(digits[15:12]), 32'h8);
    hold(4'b1000, 7'h06, 1'b0, 8);
    check("stale_clear", 32'(stale[3]), 32'd0);

    // reset in the middle of a stable strobe
    hold(4'b0000, 7'h00, 1'b0, 2);
    hold(4'b0001, 7'h6F, 1'b0, 3);
    rst = 1'b1;
    tick();
    t0 = cyc;
    rst = 1'b0;
    check_reset_outputs("midrst");
    first = -1;
    for (int i = 0; i < 20 && first < 0; i++) begin
      tick();
      if (digits[3:0] === 4'd9 && blank[0] === 1'b0) first = cyc;
    end
    check("midrst_commit", 32'(first), 32'(t0 + STABLE + 1));

    // random strobes
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 9))
        0: a = 4'b0000;
        1: a = 4'(1 << $urandom_range(0, 3)) | 4'(1 << $urandom_range(0, 3)) | 4'b0001;
        default: a = 4'(1 << $urandom_range(0, 3));
      endcase
      hold(a, ($urandom_range(0, 3) == 0) ? 7'($urandom) : tab[$urandom_range(0, 9)],
           1'($urandom), $urandom_range(1, 8));
    end
    hold(4'b0000, 7'h00, 1'b0, 70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
